fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and runs a request/done handshake with the instruction memory. Each cycle it presents either a fetched instruction or a NOP bubble, together with `fetch_addr_out`, `PC_addr_out` (PC+2) and `wait_out`, for IF/ID to latch. It also absorbs hazard stalls, branch/jump redirects and HALT.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, default 16'h0800: bubble instruction (opcode 5'b00001).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit holds IF/ID; the current output must be held.
- `redirect_en`  in  1  taken branch/jump/JR resolved downstream.
- `redirect_addr`  in  16  redirect target.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  16  request address; always equals the current PC.
- `imem_data`  in  16  returned instruction word.
- `imem_done`  in  1  one-cycle pulse; `imem_data` is valid in that cycle.
- `instruction_out`  out  16  instruction for IF/ID.
- `fetch_addr_out`  out  16  address the instruction was fetched from.
- `PC_addr_out`  out  16  `fetch_addr_out` + 2.
- `wait_out`  out  1  1 = output is a bubble (NOP_INSTR).
- `halt_out`  out  1  a HALT (opcode 5'b00000) has been delivered; fetch is stopped.
- `err`  out  1  one-cycle pulse when `redirect_en` arrives with `redirect_addr[0]`=1.

## Operation
- FSM states:
  - `FETCH`: drive `imem_req`=1 and `imem_addr`=pc; go to `WAIT`.
  - `WAIT`: hold `imem_req`=1 until `imem_done`.
  - `HOLD`: a fetched word is parked while `stall`=1.
  - `HALTED`: no requests.
- In `WAIT`, when `imem_done` arrives with no discard pending:
  - If `stall`=0: present `imem_data` with `wait_out`=0, set pc <= pc+2, go to `FETCH`.
  - If `stall`=1: park the word, go to `HOLD`.
- In `HOLD`, when `stall` drops: present the parked word for that cycle, set pc <= pc+2, go to `FETCH`.
- While no valid word is available, outputs show a bubble: `instruction_out`=NOP_INSTR, `wait_out`=1.
- Redirect:
  - Sets pc <= {redirect_addr[15:1],1'b0}, and the outputs show a bubble that cycle.
  - A parked word is dropped; the next state is `FETCH`.
  - If a request is outstanding (`WAIT`), set `discard`. The returning `imem_done` is consumed silently, then the FSM goes to `FETCH` at the new pc.
  - Redirect has priority over `stall`, and over an `imem_done` in the same cycle (that word is dropped).
- HALT:
  - When a delivered word has opcode 5'b00000, go to `HALTED` after presenting it.
  - `halt_out` goes to 1 and stays there.
  - Only reset exits `HALTED`; redirect is ignored there.
- pc arithmetic is mod 2^16: 16'hFFFE + 2 = 16'h0000, and `PC_addr_out` wraps the same way.

## Timing
- Reset values:
  - state `FETCH`, pc=RESET_PC, `discard`=0.
  - `imem_req`=0 for the reset cycle, then 1 on the first clock after deassertion.
  - `instruction_out`=NOP_INSTR, `wait_out`=1, `halt_out`=0, `err`=0.
  - `fetch_addr_out`=RESET_PC, `PC_addr_out`=RESET_PC+2.
- All outputs are registered.
- Memory with zero wait states (done one cycle after req): one instruction every 2 cycles.
- Outputs stay constant while `stall`=1.
- Reset asserted mid-`WAIT` drops the outstanding request immediately. A late `imem_done` after reset is ignored unless the state is `WAIT`.

## Structure
- Shared core package holds:
  - opcode constants `OP_HALT`=5'b00000 and `OP_NOP`=5'b00001;
  - the fetch state enum;
  - the `NOP_INSTR` default.
- One sub-module, `pc_reg`: 16-bit PC with async active-low reset, load-enable, and a +2 incrementer.

## Test plan
- Reset with RESET_PC=16'h0000, memory returning done one cycle after req and data=16'h4000 → at address 0x0000: `fetch_addr_out`=0x0000, `PC_addr_out`=0x0002, `wait_out`=0; the next request goes to 0x0002.
- `stall`=1 for 3 cycles while `imem_done` arrives → state `HOLD`, outputs constant; after `stall` drops the word is presented once and pc advances by 2 exactly once.
- `redirect_en` with addr=0x0100 during `WAIT` → the returning word is discarded; the next `imem_addr`=0x0100; the outputs show a bubble until the 0x0100 word is delivered.
- Redirect with addr=0x0101 → `err` pulses for one cycle; `imem_addr`=0x0100.
- Fetch 16'h0000 at address 0x0010 → it is presented, then `halt_out`=1, `imem_req`=0 forever; a later redirect has no effect.
- Force pc=0xFFFE → `PC_addr_out`=0x0000, and the next fetch goes to 0x0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcodes, fetch FSM states and bubble default shared by the fetch stage
package fetch_stage_pkg;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP = 5'b00001;
  localparam logic [15:0] NOP_INSTR_DEF = {OP_NOP, 11'd0};
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: 16-bit program counter with load and +2 increment
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [15:0] ld_val,
  input  logic        inc,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2
);
  assign pc_plus2 = pc + 16'd2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= RESET_PC;
    else if (ld) pc <= ld_val;
    else if (inc) pc <= pc_plus2;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, runs the imem req/done handshake and feeds IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instruction_out,
  output logic [15:0] fetch_addr_out,
  output logic [15:0] PC_addr_out,
  output logic        wait_out,
  output logic        halt_out,
  output logic        err
);
  fetch_state_t state, nxt;
  logic discard, rdr, got, present, park, halt_w;
  logic [15:0] held, word, pc, pc_plus2;
  assign imem_addr = pc;
  assign rdr = redirect_en && state != S_HALTED;
  assign got = state == S_WAIT && imem_done && !discard;
  assign word = state == S_HOLD ? held : imem_data;
  assign present = !rdr && !stall && (got || state == S_HOLD);
  assign park = !rdr && stall && got;
  assign halt_w = present && word[15:11] == OP_HALT;
  // a redirect in WAIT keeps waiting so the in-flight word can be swallowed
  always_comb
    nxt = rdr ? ((state == S_WAIT && !imem_done) ? S_WAIT : S_FETCH) :
          state == S_FETCH ? S_WAIT :
          state == S_WAIT ? (!imem_done ? S_WAIT : park ? S_HOLD : halt_w ? S_HALTED : S_FETCH) :
          state == S_HOLD ? (stall ? S_HOLD : halt_w ? S_HALTED : S_FETCH) : S_HALTED;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .ld(rdr),
    .ld_val({redirect_addr[15:1], 1'b0}),
    .inc(present),
    .pc(pc),
    .pc_plus2(pc_plus2)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_FETCH;
      discard <= 1'b0;
      held <= NOP_INSTR;
      imem_req <= 1'b0;
      instruction_out <= NOP_INSTR;
      fetch_addr_out <= RESET_PC;
      PC_addr_out <= RESET_PC + 16'd2;
      wait_out <= 1'b1;
      halt_out <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      discard <= rdr ? (state == S_WAIT && !imem_done) : (state == S_WAIT && imem_done) ? 1'b0 : discard;
      if (park) held <= imem_data;
      imem_req <= nxt == S_FETCH || nxt == S_WAIT;
      err <= rdr && redirect_addr[0];
      halt_out <= halt_out || halt_w;
      if (present) begin
        instruction_out <= word;
        fetch_addr_out <= pc;
        PC_addr_out <= pc_plus2;
        wait_out <= 1'b0;
      end else if (rdr || !stall) begin
        instruction_out <= NOP_INSTR;
        wait_out <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stall/redirect traffic against an address-stream model with a scoreboard
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  localparam logic [15:0] NOP = 16'h0800;
  typedef struct packed {logic [15:0] a; logic [15:0] d;} exp_t;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect_en = 1'b0, imem_done = 1'b0;
  logic [15:0] redirect_addr = 16'h0, imem_data = 16'h0;
  logic imem_req, wait_out, halt_out, err;
  logic [15:0] imem_addr, instruction_out, fetch_addr_out, PC_addr_out;
  logic [15:0] mem [0:32767];
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, delivered = 0, idle = 0;
  logic active = 1'b0, model_halted = 1'b0, rd;
  logic [15:0] nxt_addr = 16'h0, wrap;
  logic preq = 1'b0, pdone = 1'b0;
  logic [15:0] paddr = 16'h0;
  logic [48:0] prev;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_addr(redirect_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_done(imem_done),
    .instruction_out(instruction_out),
    .fetch_addr_out(fetch_addr_out),
    .PC_addr_out(PC_addr_out),
    .wait_out(wait_out),
    .halt_out(halt_out),
    .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // memory answers one cycle after it sees a request; stimulus and expectations are issued together
  task automatic cycle(input logic s, input logic re, input logic [15:0] ra);
    logic d;
    @(negedge clk);
    d = pdone ? 1'b0 : preq;
    imem_done = d;
    imem_data = d ? mem[paddr[15:1]] : 16'($urandom);
    pdone = d;
    preq = imem_req;
    paddr = imem_addr;
    stall = s;
    redirect_en = re;
    redirect_addr = ra;
    if (re && !model_halted) begin
      q.delete();
      nxt_addr = {ra[15:1], 1'b0};
    end
    while (q.size() < 4) begin
      q.push_back({nxt_addr, mem[nxt_addr[15:1]]});
      nxt_addr = nxt_addr + 16'd2;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (active) begin
      rd = redirect_en && !model_halted;
      chk("err", err, rd && redirect_addr[0]);
      if (rd) begin
        chk("redirect_bubble", wait_out, 1);
        chk("redirect_imem_addr", imem_addr, {redirect_addr[15:1], 1'b0});
      end else if (stall) begin
        chk("stall_hold", {instruction_out, fetch_addr_out, PC_addr_out, wait_out}, prev);
      end else if (wait_out) begin
        chk("bubble_nop", instruction_out, NOP);
      end else if (model_halted || q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual=%0h@%0h required=none", instruction_out, fetch_addr_out);
      end else begin
        e = q.pop_front();
        wrap = e.a + 16'd2;
        chk("fetch_addr", fetch_addr_out, e.a);
        chk("instruction", instruction_out, e.d);
        chk("pc_addr", PC_addr_out, wrap);
        delivered++;
        idle = 0;
        if (e.d[15:11] == OP_HALT) model_halted = 1'b1;
      end
      chk("halt_out", halt_out, model_halted);
      if (model_halted) chk("halted_no_req", imem_req, 0);
      if (!model_halted) idle++;
      if (idle > 200) begin
        checks++;
        failures++;
        $display("FAIL delivery_timeout actual=none required=delivery within 200 cycles");
        idle = 0;
      end
    end
    prev = {instruction_out, fetch_addr_out, PC_addr_out, wait_out};
  end
  initial begin
    logic [15:0] ra;
    int k;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:11] == OP_HALT) mem[i][11] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_wait", wait_out, 1);
    chk("rst_halt", halt_out, 0);
    chk("rst_err", err, 0);
    chk("rst_fetch_addr", fetch_addr_out, 16'h0000);
    chk("rst_pc_addr", PC_addr_out, 16'h0002);
    chk("rst_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    rst = 1'b1;
    while (q.size() < 4) begin
      q.push_back({nxt_addr, mem[nxt_addr[15:1]]});
      nxt_addr = nxt_addr + 16'd2;
    end
    active = 1'b1;
    @(posedge clk);
    #2;
    chk("first_req", imem_req, 1);
    chk("first_imem_addr", imem_addr, 16'h0000);
    repeat (3000) begin
      k = $urandom_range(0, 9);
      ra = k == 0 ? 16'hFFFE : k == 1 ? 16'hFFFF : 16'($urandom_range(0, 16'h03FF));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, ra);
    end
    cycle(1'b0, 1'b1, 16'h0101);
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'hFFFE);
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0200);
    mem[8] = 16'h0000;
    cycle(1'b0, 1'b1, 16'h0010);
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h0100);
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    #2;
    chk("halt_final", halt_out, 1);
    chk("progress", delivered > 300, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
